// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the 7-segment scan arbiter.
// All pin-level patterns are active-low.
package seg_pkg;

    localparam logic [3:0] DIGIT_OFF = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] DIG_SEL_0 = 4'b1110;
    localparam logic [3:0] DIG_SEL_1 = 4'b1101;
    localparam logic [3:0] DIG_SEL_2 = 4'b1011;
    localparam logic [3:0] DIG_SEL_3 = 4'b0111;

    typedef enum logic {
        SHOW_SCORE = 1'b0,
        SHOW_MSG   = 1'b1
    } state_t;

    function automatic logic [3:0] digit_sel(input logic [1:0] idx);
        logic [3:0] sel;
        sel = DIGIT_OFF;
        unique case (idx)
            2'd0: sel = DIG_SEL_0;
            2'd1: sel = DIG_SEL_1;
            2'd2: sel = DIG_SEL_2;
            2'd3: sel = DIG_SEL_3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low a..g segment pattern.
// Codes 10..15 render as a blank digit.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_arbiter.sv
// 4-digit multiplexed display scanner shared between a score source
// and a one-shot message source; sources switch only on frame boundaries.
module seg_scan_arbiter
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score_bcd,
    input  logic        msg_req,
    input  logic [15:0] msg_bcd,
    output logic        msg_ack,
    output logic        msg_busy,
    input  logic        blank_en,
    output logic [3:0]  DIGIT,
    output logic [6:0]  DISPLAY
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [1:0]    idx_nx;
    logic          tick;
    logic          frame;

    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nx;
    logic [15:0]   msg_reg;
    logic [15:0]   msg_nx;
    logic [15:0]   fbuf;
    logic [15:0]   fbuf_nx;
    logic          regrant;
    logic          regrant_nx;

    logic [3:0]    nib;
    logic [6:0]    seg_nx;

    assign tick   = (presc == PW'(SCAN_DIV - 1));
    assign idx_nx = idx + 2'd1;
    assign frame  = tick && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= 2'd3;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx_nx;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        state_nx   = state;
        hold_nx    = hold;
        msg_nx     = msg_reg;
        fbuf_nx    = fbuf;
        regrant_nx = regrant;
        msg_ack    = 1'b0;
        msg_busy   = (state == SHOW_MSG);
        unique case (state)
            SHOW_SCORE: begin
                if (frame) begin
                    fbuf_nx = score_bcd;
                    if (msg_req && regrant) begin
                        msg_nx   = msg_bcd;
                        fbuf_nx  = msg_bcd;
                        msg_ack  = 1'b1;
                        hold_nx  = HW'(HOLD_FRAMES - 1);
                        state_nx = SHOW_MSG;
                    end
                end else if (tick) begin
                    // a score frame has started, so by its end it is complete
                    regrant_nx = 1'b1;
                end
            end
            SHOW_MSG: begin
                if (frame) begin
                    if (hold != '0) begin
                        hold_nx = hold - HW'(1);
                        fbuf_nx = msg_reg;
                    end else begin
                        state_nx   = SHOW_SCORE;
                        regrant_nx = 1'b0;
                        fbuf_nx    = score_bcd;
                    end
                end
            end
            default: state_nx = SHOW_SCORE;
        endcase
    end

    always_comb begin
        nib = fbuf_nx[3:0];
        unique case (idx_nx)
            2'd0: nib = fbuf_nx[3:0];
            2'd1: nib = fbuf_nx[7:4];
            2'd2: nib = fbuf_nx[11:8];
            2'd3: nib = fbuf_nx[15:12];
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (nib),
        .seg (seg_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SHOW_SCORE;
            hold    <= '0;
            msg_reg <= '0;
            fbuf    <= 16'hFFFF;
            regrant <= 1'b1;
        end else begin
            state   <= state_nx;
            hold    <= hold_nx;
            msg_reg <= msg_nx;
            fbuf    <= fbuf_nx;
            regrant <= regrant_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DIGIT   <= DIGIT_OFF;
            DISPLAY <= SEG_BLANK;
        end else if (tick) begin
            if (blank_en) begin
                DIGIT   <= DIGIT_OFF;
                DISPLAY <= SEG_BLANK;
            end else begin
                DIGIT   <= digit_sel(idx_nx);
                DISPLAY <= seg_nx;
            end
        end
    end

endmodule
